// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache between fetch and IRAM.
//
// Hits are looked up combinationally and answered in the same cycle. A miss
// latches the request and runs a request/acknowledge refill from IRAM. The
// returned line is forwarded to fetch in the ack cycle. A flush sweeps the
// valid bits one set per cycle.
//
// Build option: define ICACHE_LRU_EN for true per-set LRU replacement.
// Without it, each set uses a round-robin fill counter.
//
// Ports:
//   clk, nrst      clock, synchronous active-low reset
//   i_req_valid    fetch presents i_req_pc this cycle
//   i_req_pc       fetch address (bits [1:0] ignored)
//   i_flush        full invalidate request, 1-cycle pulse
//   o_resp_valid   o_resp_instr is valid this cycle
//   o_resp_instr   fetched instruction, 0 when o_resp_valid=0
//   o_stall        cache busy; fetch holds i_req_pc
//   o_mem_req      IRAM block request, held until i_mem_ack
//   o_mem_addr     block-aligned IRAM address
//   i_mem_ack      i_mem_block valid, 1-cycle pulse
//   i_mem_block    refill line, byte k at bits [8k:8k+7]
module icache_sa #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned SETS    = 16,
  parameter int unsigned WAYS    = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_req_valid,
  input  logic [PC_W-1:0]    i_req_pc,
  input  logic               i_flush,
  output logic               o_resp_valid,
  output logic [INSTR_W-1:0] o_resp_instr,
  output logic               o_stall,
  output logic               o_mem_req,
  output logic [PC_W-1:0]    o_mem_addr,
  input  logic               i_mem_ack,
  input  logic [0:BLOCK_W-1] i_mem_block
);

  localparam int unsigned OFF    = $clog2(BLOCK_W / 8);
  localparam int unsigned IDX    = $clog2(SETS);
  localparam int unsigned TAG_W  = PC_W - OFF - IDX;
  localparam int unsigned WSEL_W = OFF - 2;
  localparam int unsigned WAY_W  = $clog2(WAYS);

  typedef enum logic [1:0] {StIdle, StMiss, StFlush} state_e;

  state_e r_state, w_state_next;

  logic [0:BLOCK_W-1] r_data  [SETS][WAYS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [WAYS-1:0]    r_valid [SETS];

  logic [TAG_W-1:0]  r_miss_tag;
  logic [IDX-1:0]    r_miss_set;
  logic [WSEL_W-1:0] r_miss_word;
  logic              r_flush_pend;
  logic [IDX-1:0]    r_flush_set;

  logic [TAG_W-1:0]   w_req_tag;
  logic [IDX-1:0]     w_req_set;
  logic [WSEL_W-1:0]  w_req_word;
  logic               w_hit_any;
  logic [WAY_W-1:0]   w_hit_way;
  logic [INSTR_W-1:0] w_hit_word;
  logic [INSTR_W-1:0] w_fill_word;
  logic [WAY_W-1:0]   w_victim;
  logic               w_has_inv;
  logic               w_hit_acc;
  logic               w_fill;

  assign w_req_tag  = i_req_pc[PC_W-1:OFF+IDX];
  assign w_req_set  = i_req_pc[OFF+IDX-1:OFF];
  assign w_req_word = i_req_pc[OFF-1:2];

  // Little-endian word assembled from an ascending-byte line.
  function automatic logic [INSTR_W-1:0] f_word(input logic [0:BLOCK_W-1] line,
                                                input logic [WSEL_W-1:0] sel);
    logic [INSTR_W-1:0] word;
    word = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      word[8*b +: 8] = line[8*(4*int'(sel) + b) +: 8];
    end
    return word;
  endfunction

  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_hit_any && r_valid[w_req_set][w] && (r_tag[w_req_set][w] == w_req_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_hit_word  = f_word(r_data[w_req_set][w_hit_way], w_req_word);
  assign w_fill_word = f_word(i_mem_block, r_miss_word);

`ifdef ICACHE_LRU_EN
  logic [WAY_W-1:0] r_age [SETS][WAYS];
  logic [IDX-1:0]   w_acc_set;
  logic [WAY_W-1:0] w_acc_way;
  logic [WAY_W-1:0] w_acc_old;
  logic             w_unused;

  assign w_acc_set = w_fill ? r_miss_set : w_req_set;
  assign w_acc_way = w_fill ? w_victim : w_hit_way;
  assign w_acc_old = r_age[w_acc_set][w_acc_way];
  assign w_unused  = ^i_req_pc[1:0];
`else
  logic [WAY_W-1:0] r_rr [SETS];
  logic             w_unused;

  assign w_unused = ^{i_req_pc[1:0], w_hit_acc};
`endif

  // Victim: lowest invalid way first, otherwise the replacement policy.
  always_comb begin
    w_victim  = '0;
    w_has_inv = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_has_inv && !r_valid[r_miss_set][w]) begin
        w_has_inv = 1'b1;
        w_victim  = WAY_W'(w);
      end
    end
    if (!w_has_inv) begin
`ifdef ICACHE_LRU_EN
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (r_age[r_miss_set][w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
      end
`else
      w_victim = r_rr[r_miss_set];
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_flush)                        w_state_next = StFlush;
        else if (i_req_valid && !w_hit_any) w_state_next = StMiss;
      end
      StMiss: begin
        if (i_mem_ack) w_state_next = (r_flush_pend || i_flush) ? StFlush : StIdle;
      end
      StFlush: begin
        if (r_flush_set == IDX'(SETS - 1)) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_resp_valid = 1'b0;
    o_resp_instr = '0;
    o_stall      = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_addr   = '0;
    w_hit_acc    = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          // A same-cycle flush wins; the request is held off, not serviced.
          if (!i_flush && w_hit_any) begin
            o_resp_valid = 1'b1;
            o_resp_instr = w_hit_word;
            w_hit_acc    = 1'b1;
          end else begin
            o_stall = 1'b1;
          end
        end
      end
      StMiss: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_miss_tag, r_miss_set, {OFF{1'b0}}};
        if (i_mem_ack) begin
          // Forwarded word releases fetch in the ack cycle.
          o_resp_valid = 1'b1;
          o_resp_instr = w_fill_word;
          w_fill       = 1'b1;
        end else begin
          o_stall = 1'b1;
        end
      end
      StFlush: o_stall = 1'b1;
      default: ;
    endcase
  end

  // Control, valid bits and replacement state.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_miss_tag   <= '0;
      r_miss_set   <= '0;
      r_miss_word  <= '0;
      r_flush_pend <= 1'b0;
      r_flush_set  <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
`ifdef ICACHE_LRU_EN
        for (int unsigned w = 0; w < WAYS; w++) r_age[s][w] <= '0;
`else
        r_rr[s] <= '0;
`endif
      end
    end else begin
      if (r_state == StIdle && i_req_valid && !i_flush && !w_hit_any) begin
        r_miss_tag  <= w_req_tag;
        r_miss_set  <= w_req_set;
        r_miss_word <= w_req_word;
      end
      if (r_state == StMiss) begin
        if (i_mem_ack)    r_flush_pend <= 1'b0;
        else if (i_flush) r_flush_pend <= 1'b1;
      end
      if (r_state == StFlush) begin
        r_valid[r_flush_set] <= '0;
        r_flush_set          <= r_flush_set + IDX'(1);
      end
      if (w_fill) r_valid[r_miss_set][w_victim] <= 1'b1;
`ifdef ICACHE_LRU_EN
      // Accessed way becomes youngest. Ties (only right after reset) also age,
      // which settles the ages into a proper ordering as ways are filled.
      if (w_hit_acc || w_fill) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_acc_way) begin
            r_age[w_acc_set][w] <= '0;
          end else if (r_age[w_acc_set][w] <= w_acc_old &&
                       r_age[w_acc_set][w] != WAY_W'(WAYS - 1)) begin
            r_age[w_acc_set][w] <= r_age[w_acc_set][w] + WAY_W'(1);
          end
        end
      end
`else
      if (w_fill) r_rr[r_miss_set] <= r_rr[r_miss_set] + WAY_W'(1);
`endif
    end
  end

  // Line data and tags need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[r_miss_set][w_victim] <= i_mem_block;
      r_tag[r_miss_set][w_victim]  <= r_miss_tag;
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Testbench for icache_sa: directed scenarios plus randomized accesses checked
// against a behavioural model of resident lines per set.
module tb_icache_sa;

  localparam int SETS = 16;
  localparam int WAYS = 2;

  logic         clk;
  logic         nrst;
  logic         req_valid;
  logic [31:0]  req_pc;
  logic         flush;
  logic         resp_valid;
  logic [31:0]  resp_instr;
  logic         stall;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [0:127] mem_block;

  int n_checks;
  int n_errors;

  icache_sa #(
    .PC_W    (32),
    .INSTR_W (32),
    .BLOCK_W (128),
    .SETS    (SETS),
    .WAYS    (WAYS)
  ) u_dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_req_valid  (req_valid),
    .i_req_pc     (req_pc),
    .i_flush      (flush),
    .o_resp_valid (resp_valid),
    .o_resp_instr (resp_instr),
    .o_stall      (stall),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_block  (mem_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per set and way, whether a line is resident and its tag.
  bit m_valid [SETS][WAYS];
  int unsigned m_tag [SETS][WAYS];
  int m_stamp [SETS][WAYS];
  int m_rr [SETS];
  int m_time;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive at posedge+1, sample at posedge+5.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] h;
    h = 8'(a[31:8] * 37) ^ 8'd37;
    return a[7:0] ^ h;
  endfunction

  function automatic logic [0:127] make_block(input logic [31:0] base);
    logic [0:127] blk;
    for (int k = 0; k < 16; k++) blk[8*k +: 8] = mem_byte(base + 32'(k));
    return blk;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] b;
    b = pc & ~32'h3;
    return {mem_byte(b + 3), mem_byte(b + 2), mem_byte(b + 1), mem_byte(b)};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_stamp[s][w] = 0;
      end
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, output bit hit, output int way);
    int s;
    s = int'(pc[7:4]);
    hit = 0;
    way = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == int'(pc[31:8])) begin
        hit = 1;
        way = w;
      end
    end
  endtask

  task automatic model_fill(input logic [31:0] pc);
    int s;
    int v;
    bit found;
    s = int'(pc[7:4]);
    found = 0;
    v = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !m_valid[s][w]) begin
        found = 1;
        v = w;
      end
    end
    if (!found) begin
`ifdef ICACHE_LRU_EN
      // Least recently accessed line goes.
      v = 0;
      for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][v]) v = w;
`else
      v = m_rr[s];
`endif
    end
    m_valid[s][v] = 1;
    m_tag[s][v] = int'(pc[31:8]);
    m_stamp[s][v] = ++m_time;
    m_rr[s] = (m_rr[s] + 1) % WAYS;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req_valid = 1'b0;
    req_pc = '0;
    flush = 1'b0;
    mem_ack = 1'b0;
    mem_block = '0;
    tick();
    tick();
    nrst = 1'b1;
    model_reset();
  endtask

  // Count consecutive stall cycles starting in the current cycle.
  task automatic count_flush(input string tag);
    int n;
    n = 0;
    req_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #4;
      if (stall) begin
        n++;
        tick();
      end else begin
        break;
      end
    end
    tick();
    check_eq(tag, 64'(n), 64'(SETS));
  endtask

  task automatic do_flush_idle();
    req_valid = 1'b0;
    flush = 1'b1;
    #4;
    check_eq("flush_pulse_stall", 64'(stall), 64'd0);
    tick();
    flush = 1'b0;
    count_flush("flush_len");
    model_flush();
  endtask

  task automatic do_access(input logic [31:0] pc, input int ack_delay, input bit flush_mid,
                           output bit obs_hit);
    bit mhit;
    int mway;
    logic [31:0] baddr;
    baddr = pc & ~32'hF;
    model_lookup(pc, mhit, mway);
    req_valid = 1'b1;
    req_pc = pc;
    flush = 1'b0;
    mem_ack = 1'b0;
    #4;
    obs_hit = resp_valid;
    if (mhit) begin
      check_eq("hit_valid", 64'(resp_valid), 64'd1);
      check_eq("hit_instr", 64'(resp_instr), 64'(exp_word(pc)));
      check_eq("hit_stall", 64'(stall), 64'd0);
      m_stamp[int'(pc[7:4])][mway] = ++m_time;
      tick();
    end else begin
      check_eq("miss_stall", 64'(stall), 64'd1);
      check_eq("miss_rvalid", 64'(resp_valid), 64'd0);
      check_eq("miss_instr", 64'(resp_instr), 64'd0);
      tick();
      for (int i = 0; i < ack_delay; i++) begin
        flush = (flush_mid && i == 0);
        #4;
        check_eq("wait_mem_req", 64'(mem_req), 64'd1);
        check_eq("wait_mem_addr", 64'(mem_addr), 64'(baddr));
        check_eq("wait_stall", 64'(stall), 64'd1);
        check_eq("wait_rvalid", 64'(resp_valid), 64'd0);
        tick();
      end
      flush = (flush_mid && ack_delay == 0);
      mem_ack = 1'b1;
      mem_block = make_block(baddr);
      #4;
      check_eq("ack_mem_addr", 64'(mem_addr), 64'(baddr));
      check_eq("ack_rvalid", 64'(resp_valid), 64'd1);
      check_eq("ack_instr", 64'(resp_instr), 64'(exp_word(pc)));
      model_fill(pc);
      tick();
      mem_ack = 1'b0;
      flush = 1'b0;
      req_valid = 1'b0;
      if (flush_mid) begin
        count_flush("flush_after_refill_len");
        model_flush();
      end
    end
  endtask

  initial begin
    bit h;
    logic [31:0] pc;
    int r;
    n_checks = 0;
    n_errors = 0;
    m_time = 0;

    do_reset();
    #4;
    check_eq("rst_rvalid", 64'(resp_valid), 64'd0);
    check_eq("rst_instr", 64'(resp_instr), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    tick();

    // Cold miss, re-hit, word select.
    do_access(32'h100, 3, 0, h);
    check_eq("cold_is_miss", 64'(h), 64'd0);
    do_access(32'h100, 0, 0, h);
    check_eq("rehit", 64'(h), 64'd1);
    check_eq("rehit_instr_const", 64'(resp_instr), 64'h03020100);
    do_access(32'h10C, 0, 0, h);
    check_eq("word_sel_instr", 64'(resp_instr), 64'h0F0E0D0C);

    // Replacement in set 0.
    do_reset();
    do_access(32'h000, 1, 0, h);
    do_access(32'h100, 1, 0, h);
    do_access(32'h000, 1, 0, h);
    do_access(32'h200, 1, 0, h);
    do_access(32'h000, 1, 0, h);
`ifdef ICACHE_LRU_EN
    check_eq("repl_000_kept", 64'(h), 64'd1);
`else
    check_eq("repl_000_evicted", 64'(h), 64'd0);
`endif

    // Flush in idle, then a previously cached PC misses.
    do_access(32'h340, 0, 0, h);
    do_flush_idle();
    do_access(32'h340, 1, 0, h);
    check_eq("post_flush_miss", 64'(h), 64'd0);

    // Flush during refill.
    do_access(32'h450, 2, 1, h);
    do_access(32'h450, 1, 0, h);
    check_eq("post_refill_flush_miss", 64'(h), 64'd0);

    // Reset mid-refill with a stray late ack.
    req_valid = 1'b1;
    req_pc = 32'h560;
    #4;
    check_eq("rmr_stall", 64'(stall), 64'd1);
    tick();
    #4;
    check_eq("rmr_mem_req", 64'(mem_req), 64'd1);
    tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    req_valid = 1'b0;
    #4;
    check_eq("rmr_mem_req_drop", 64'(mem_req), 64'd0);
    check_eq("rmr_stall_drop", 64'(stall), 64'd0);
    tick();
    mem_ack = 1'b1;
    mem_block = make_block(32'h560);
    #4;
    check_eq("stray_ack_rvalid", 64'(resp_valid), 64'd0);
    check_eq("stray_ack_instr", 64'(resp_instr), 64'd0);
    tick();
    mem_ack = 1'b0;
    model_reset();
    do_access(32'h560, 2, 0, h);
    check_eq("rmr_remiss", 64'(h), 64'd0);

    // Randomized traffic over a small conflicting address pool.
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        do_flush_idle();
      end else begin
        pc = ($urandom_range(0, 4) << 8) | ($urandom_range(0, 3) << 4) |
             ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        do_access(pc, int'($urandom_range(0, 3)), r < 14, h);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
